// File: rtl/mac_rx_pkg.sv
// rtl/mac_rx_pkg.sv - shared constants, descriptor layout and state encoding for the rx classifier
package mac_rx_pkg;

  localparam int          HDR_LEN          = 14;
  localparam logic [31:0] CRC_RESIDUE      = 32'hc704dd7b;
  localparam int          DESC_LEN_MSB     = 12;
  localparam int          DESC_TRUNC_BIT   = 13;
  localparam int          DESC_LEN_ERR_BIT = 14;
  localparam int          DESC_CRC_ERR_BIT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY,
    ST_FLUSH,
    ST_DESC,
    ST_DROP
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_8023.sv
// rtl/crc32_8023.sv - byte-wide IEEE 802.3 CRC-32 accumulator
// Runs the reflected polynomial; crc_o is bit-reversed so the good-frame residue reads 32'hc704dd7b.
module crc32_8023 (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  d_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] seed;

  always_comb begin
    seed  = init_i ? 32'hFFFF_FFFF : crc_q;
    crc_d = seed;
    if (en_i) begin
      crc_d = seed ^ {24'd0, d_i};
      for (int b = 0; b < 8; b++) begin
        crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hEDB8_8320) : (crc_d >> 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  for (genvar g = 0; g < 32; g++) begin : g_rev
    assign crc_o[g] = crc_q[31-g];
  end

endmodule

// File: rtl/mac_r_class_nq.sv
// rtl/mac_r_class_nq.sv - rx frame classifier steering bytes and descriptors into NQ queues
// Holds the 14-byte header in a delay line so the queue is known before the first byte is written.
module mac_r_class_nq
  import mac_rx_pkg::*;
#(
  parameter int NQ  = 2,
  parameter int MTU = 1500
) (
  input  logic             rx_clk,
  input  logic             rstn_mac,
  input  logic             rx_dv,
  input  logic             rx_en,
  input  logic [7:0]       rx_d,
  input  logic [16*NQ-1:0] class_type,
  input  logic [NQ-1:0]    class_en,
  input  logic [NQ-1:0]    q_afull,
  input  logic [NQ-1:0]    desc_full,
  output logic [7:0]       q_din,
  output logic [NQ-1:0]    q_wr,
  output logic [15:0]      desc_din,
  output logic [NQ-1:0]    desc_wr,
  output logic [16*NQ-1:0] drop_cnt,
  output logic [15:0]      runt_cnt
);

  localparam int             SW         = (NQ > 2) ? 2 : 1;
  localparam logic [12:0]    FRAME_MAX  = 13'(MTU + 18);
  localparam logic [NQ-1:0]  ONE_Q      = {{(NQ-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic            dv_q;
  logic            pend_drop_q, pend_drop_d;
  logic [SW-1:0]   sel_q, sel_d, cls;
  logic [12:0]     in_cnt_q, in_cnt_d;
  logic [12:0]     out_cnt_q, out_cnt_d;
  logic            trunc_q, trunc_d;
  logic [3:0]      fl_cnt_q, fl_cnt_d;
  logic [7:0]      dline_q [HDR_LEN];
  logic [7:0]      q_din_q, q_din_d;
  logic [NQ-1:0]   q_wr_q, q_wr_d;
  logic [15:0]     desc_din_q, desc_din_d;
  logic [NQ-1:0]   desc_wr_q, desc_wr_d;
  logic [15:0]     drop_q [NQ];
  logic [15:0]     drop_d [NQ];
  logic [15:0]     runt_q, runt_d;

  logic            acc, rise, push, crc_init, crc_en, dl_shift;
  logic [15:0]     etype;
  logic [12:0]     wr_len;
  logic [31:0]     crc_res;
  logic            unused_cfg;

  assign acc        = rx_dv & rx_en;
  assign rise       = rx_dv & ~dv_q;
  assign etype      = {dline_q[0], rx_d};
  assign dl_shift   = acc | (state_q == ST_FLUSH);
  assign wr_len     = (out_cnt_q < FRAME_MAX) ? out_cnt_q : FRAME_MAX;
  assign unused_cfg = ^{class_type[15:0], class_en[0]};

  crc32_8023 u_crc (
    .clk_i  (rx_clk),
    .rstn_i (rstn_mac),
    .init_i (crc_init),
    .en_i   (crc_en),
    .d_i    (rx_d),
    .crc_o  (crc_res)
  );

  // Descending scan so the lowest matching queue wins.
  always_comb begin
    cls = '0;
    for (int q = NQ - 1; q >= 1; q--) begin
      if (class_en[q] && (class_type[q*16 +: 16] == etype)) cls = q[SW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_drop_d = pend_drop_q;
    sel_d       = sel_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    trunc_d     = trunc_q;
    fl_cnt_d    = fl_cnt_q;
    q_din_d     = q_din_q;
    q_wr_d      = '0;
    desc_din_d  = desc_din_q;
    desc_wr_d   = '0;
    runt_d      = runt_q;
    for (int q = 0; q < NQ; q++) drop_d[q] = drop_q[q];
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      ST_IDLE: if (rise) begin
        state_d     = ST_HDR;
        crc_init    = 1'b1;
        crc_en      = rx_en;
        in_cnt_d    = rx_en ? 13'd1 : 13'd0;
        out_cnt_d   = '0;
        trunc_d     = 1'b0;
        pend_drop_d = 1'b0;
      end
      ST_HDR: begin
        if (!rx_dv) begin
          runt_d  = sat_inc16(runt_q);
          state_d = ST_IDLE;
        end else if (rx_en) begin
          crc_en   = 1'b1;
          in_cnt_d = in_cnt_q + 13'd1;
          if (in_cnt_q == 13'(HDR_LEN - 1)) begin
            sel_d = cls;
            if (q_afull[cls] || desc_full[cls]) begin
              drop_d[cls] = sat_inc16(drop_q[cls]);
              state_d     = ST_DROP;
            end else begin
              state_d = ST_BODY;
            end
          end
        end
      end
      ST_BODY: begin
        if (!rx_dv) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = '0;
        end else if (rx_en) begin
          crc_en   = 1'b1;
          push     = 1'b1;
          in_cnt_d = (in_cnt_q == 13'h1FFF) ? in_cnt_q : in_cnt_q + 13'd1;
        end
      end
      ST_FLUSH: begin
        push     = 1'b1;
        fl_cnt_d = fl_cnt_q + 4'd1;
        if (rise && !pend_drop_q) begin
          pend_drop_d = 1'b1;
          drop_d[0]   = sat_inc16(drop_q[0]);
        end
        if (fl_cnt_q == 4'(HDR_LEN - 1)) state_d = ST_DESC;
      end
      ST_DESC: begin
        desc_wr_d  = ONE_Q << sel_q;
        desc_din_d = {crc_res != CRC_RESIDUE,
                      (in_cnt_q < 13'd64) || (in_cnt_q > FRAME_MAX),
                      trunc_q, wr_len};
        if (rise && !pend_drop_q) begin
          drop_d[0] = sat_inc16(drop_q[0]);
          state_d   = ST_DROP;
        end else if (pend_drop_q) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: if (!rx_dv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      q_din_d   = dline_q[HDR_LEN-1];
      out_cnt_d = (out_cnt_q == 13'h1FFF) ? out_cnt_q : out_cnt_q + 13'd1;
      if (out_cnt_q < FRAME_MAX) q_wr_d  = ONE_Q << sel_q;
      else                       trunc_d = 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rstn_mac) begin
      state_q     <= ST_IDLE;
      // Held high so a frame already in progress at release is not mistaken for a new one.
      dv_q        <= 1'b1;
      pend_drop_q <= 1'b0;
      sel_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      trunc_q     <= 1'b0;
      fl_cnt_q    <= '0;
      q_din_q     <= '0;
      q_wr_q      <= '0;
      desc_din_q  <= '0;
      desc_wr_q   <= '0;
      runt_q      <= '0;
      for (int q = 0; q < NQ; q++) drop_q[q] <= '0;
      for (int i = 0; i < HDR_LEN; i++) dline_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dv_q        <= rx_dv;
      pend_drop_q <= pend_drop_d;
      sel_q       <= sel_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      trunc_q     <= trunc_d;
      fl_cnt_q    <= fl_cnt_d;
      q_din_q     <= q_din_d;
      q_wr_q      <= q_wr_d;
      desc_din_q  <= desc_din_d;
      desc_wr_q   <= desc_wr_d;
      runt_q      <= runt_d;
      for (int q = 0; q < NQ; q++) drop_q[q] <= drop_d[q];
      if (dl_shift) begin
        dline_q[0] <= rx_d;
        for (int i = 1; i < HDR_LEN; i++) dline_q[i] <= dline_q[i-1];
      end
    end
  end

  assign q_din    = q_din_q;
  assign q_wr     = q_wr_q;
  assign desc_din = desc_din_q;
  assign desc_wr  = desc_wr_q;
  assign runt_cnt = runt_q;
  for (genvar g = 0; g < NQ; g++) begin : g_drop
    assign drop_cnt[g*16 +: 16] = drop_q[g];
  end

endmodule

// File: tb/tb_mac_r_class_nq.sv
// tb/tb_mac_r_class_nq.sv - directed and randomized frame-level check of mac_r_class_nq
module tb_mac_r_class_nq;

  localparam int NQ   = 2;
  localparam int MTU  = 1500;
  localparam int FMAX = MTU + 18;

  logic             rx_clk = 1'b0;
  logic             rstn_mac;
  logic             rx_dv, rx_en;
  logic [7:0]       rx_d;
  logic [16*NQ-1:0] class_type;
  logic [NQ-1:0]    class_en, q_afull, desc_full;
  logic [7:0]       q_din;
  logic [NQ-1:0]    q_wr, desc_wr;
  logic [15:0]      desc_din;
  logic [16*NQ-1:0] drop_cnt;
  logic [15:0]      runt_cnt;

  mac_r_class_nq #(.NQ(NQ), .MTU(MTU)) dut (
    .rx_clk(rx_clk), .rstn_mac(rstn_mac), .rx_dv(rx_dv), .rx_en(rx_en), .rx_d(rx_d),
    .class_type(class_type), .class_en(class_en), .q_afull(q_afull), .desc_full(desc_full),
    .q_din(q_din), .q_wr(q_wr), .desc_din(desc_din), .desc_wr(desc_wr),
    .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: expected write stream and descriptors per frame, plus counters.
  logic [7:0]  frm[$];
  logic [7:0]  exp_b[$];
  int          exp_q[$];
  logic [15:0] exp_d[$];
  int          exp_dq[$];
  int          m_drop [NQ];
  int          m_runt = 0;

  bit          strict = 1'b1;
  int          wr_total = 0;
  int          desc_total = 0;
  logic [15:0] last_desc = '0;
  int          first_wr_cyc = -1;
  int          acc15_cyc = -1;

  function automatic logic [31:0] crc_calc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic mk(input int len, input logic [15:0] et, input bit good);
    logic [31:0] f;
    frm.delete();
    for (int i = 0; i < len - 4; i++)
      frm.push_back(i == 12 ? et[15:8] : (i == 13 ? et[7:0] : 8'($urandom)));
    f = ~crc_calc(len - 4);
    frm.push_back(f[7:0]);  frm.push_back(f[15:8]);
    frm.push_back(f[23:16]); frm.push_back(f[31:24]);
    if (!good) frm[len-1] = frm[len-1] ^ 8'h04;
  endtask

  task automatic model_frame(input bit overlap);
    int len, q, n;
    logic [15:0] et;
    bit fcs_ok;
    len = frm.size();
    if (overlap) begin m_drop[0]++; return; end
    if (len < 14) begin m_runt++; return; end
    et = {frm[12], frm[13]};
    q = 0;
    for (int k = NQ - 1; k >= 1; k--)
      if (class_en[k] && class_type[k*16 +: 16] == et) q = k;
    if (q_afull[q] || desc_full[q]) begin m_drop[q]++; return; end
    n = (len < FMAX) ? len : FMAX;
    for (int i = 0; i < n; i++) begin exp_q.push_back(q); exp_b.push_back(frm[i]); end
    fcs_ok = (~crc_calc(len - 4)) == {frm[len-1], frm[len-2], frm[len-3], frm[len-4]};
    exp_dq.push_back(q);
    exp_d.push_back({~fcs_ok, (len < 64) || (len > FMAX), len > FMAX, 13'(n)});
  endtask

  always @(negedge rx_clk) begin : mon
    int eq;
    if (q_wr != 0 || desc_wr != 0)
      chk("wr_exclusive", 32'((q_wr != 0) && (desc_wr != 0)), 0);
    if (q_wr != 0) begin
      wr_total++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (strict) begin
        if (exp_b.size() == 0) chk("unexpected_q_wr", 32'(q_wr), 0);
        else begin
          eq = exp_q.pop_front();
          chk("q_wr_sel", 32'(q_wr), 32'(1) << eq);
          chk("q_din", 32'(q_din), 32'(exp_b.pop_front()));
        end
      end
    end
    if (desc_wr != 0) begin
      desc_total++;
      last_desc = desc_din;
      if (strict) begin
        if (exp_d.size() == 0) chk("unexpected_desc_wr", 32'(desc_wr), 0);
        else begin
          eq = exp_dq.pop_front();
          chk("desc_wr_sel", 32'(desc_wr), 32'(1) << eq);
          chk("desc_din", 32'(desc_din), 32'(exp_d.pop_front()));
        end
      end
    end
  end

  task automatic send(input int mode, input int chg_at, input int gap);
    int  i;
    bit  alt, en;
    i = 0; alt = 1'b0;
    while (i < frm.size()) begin
      @(posedge rx_clk); #1;
      alt = ~alt;
      en  = (mode == 0) ? 1'b1 : (mode == 1) ? alt : 1'($urandom_range(0, 1));
      rx_dv = 1'b1; rx_en = en;
      rx_d  = en ? frm[i] : 8'($urandom);
      if (en) begin
        i++;
        if (i == 15) acc15_cyc = cyc;
        if (i == chg_at) begin q_afull = '1; desc_full = '1; class_en = '0; end
      end
    end
    @(posedge rx_clk); #1;
    rx_dv = 1'b0; rx_en = 1'b1;
    repeat (gap) @(posedge rx_clk);
  endtask

  task automatic end_checks();
    chk("wr_drain", exp_b.size(), 0);
    chk("desc_drain", exp_d.size(), 0);
    exp_b.delete(); exp_q.delete(); exp_d.delete(); exp_dq.delete();
    for (int k = 0; k < NQ; k++) chk("drop_cnt", drop_cnt[k*16 +: 16], m_drop[k]);
    chk("runt_cnt", runt_cnt, m_runt);
  endtask

  task automatic run_frame(input int mode, input bit overlap, input int chg_at, input int gap);
    model_frame(overlap);
    send(mode, chg_at, gap);
    if (gap >= 20) end_checks();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_q_wr"}, 32'(q_wr), 0);
    chk({nm, "_desc_wr"}, 32'(desc_wr), 0);
    chk({nm, "_q_din"}, 32'(q_din), 0);
    chk({nm, "_desc_din"}, 32'(desc_din), 0);
    chk({nm, "_drop_cnt"}, 32'(drop_cnt), 0);
    chk({nm, "_runt_cnt"}, 32'(runt_cnt), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", vectors);
    $fatal(1);
  end

  initial begin
    int w0, d0, len, r;
    logic [15:0] et;
    logic [15:0] ets [4];
    ets[0] = 16'h0800; ets[1] = 16'h88F7; ets[2] = 16'h86DD; ets[3] = 16'h8100;
    for (int k = 0; k < NQ; k++) m_drop[k] = 0;
    rstn_mac = 1'b0; rx_dv = 1'b0; rx_en = 1'b1; rx_d = '0;
    class_type = {16'h88F7, 16'h0000}; class_en = 2'b10; q_afull = '0; desc_full = '0;
    repeat (3) @(posedge rx_clk);
    @(negedge rx_clk);
    chk_zero("reset");
    @(posedge rx_clk); #1 rstn_mac = 1'b1;
    repeat (3) @(posedge rx_clk); #1;

    // 64-byte good frame to queue 0
    mk(64, 16'h0800, 1); w0 = wr_total;
    run_frame(0, 0, -1, 24);
    chk("t64_writes", wr_total - w0, 64);
    chk("t64_desc", last_desc, 16'h0040);

    // 100-byte frame, half-rate strobes, queue 1
    mk(100, 16'h88F7, 1); first_wr_cyc = -1;
    run_frame(1, 0, -1, 24);
    chk("t100_first_wr_latency", first_wr_cyc, acc15_cyc + 1);
    chk("t100_len", last_desc[12:0], 100);
    chk("t100_crc_err", last_desc[15], 0);

    // oversize frame truncated at MTU+18
    mk(2000, 16'h0800, 1); w0 = wr_total;
    run_frame(0, 0, -1, 24);
    chk("t2000_writes", wr_total - w0, 1518);
    chk("t2000_desc", last_desc, 16'h65EE);

    // backpressure drop on queue 1, then normal delivery
    q_afull = 2'b10; mk(80, 16'h88F7, 1); w0 = wr_total; d0 = desc_total;
    run_frame(0, 0, -1, 24);
    q_afull = '0;
    chk("afull_drop1", drop_cnt[31:16], 1);
    chk("afull_no_wr", wr_total - w0, 0);
    chk("afull_no_desc", desc_total - d0, 0);
    mk(80, 16'h88F7, 1);
    run_frame(2, 0, -1, 24);

    // runt
    mk(10, 16'h0800, 1); w0 = wr_total; d0 = desc_total;
    run_frame(0, 0, -1, 24);
    chk("runt_cnt_one", runt_cnt, 1);
    chk("runt_no_wr", wr_total - w0, 0);
    chk("runt_no_desc", desc_total - d0, 0);

    // single FCS bit error
    mk(64, 16'h0800, 0);
    run_frame(0, 0, -1, 24);
    chk("badfcs_bit15", last_desc[15], 1);

    // config changes after classification must not matter
    mk(60, 16'h88F7, 1);
    run_frame(0, 0, 20, 24);
    q_afull = '0; desc_full = '0; class_en = 2'b10;

    // new frame starting during flush is dropped, pending descriptor still written
    mk(70, 16'h0800, 1);
    run_frame(0, 0, -1, 3);
    mk(50, 16'h88F7, 1);
    run_frame(0, 1, -1, 24);

    // randomized frames and configuration
    for (int it = 0; it < 14; it++) begin
      r = $urandom_range(0, 9);
      len = (r == 0) ? $urandom_range(4, 13) : (r == 1) ? $urandom_range(1490, 1560)
                                             : $urandom_range(14, 200);
      et = ets[$urandom_range(0, 3)];
      class_type[31:16] = ets[$urandom_range(0, 3)];
      class_en  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      q_afull   = ($urandom_range(0, 7) == 0) ? NQ'($urandom) : '0;
      desc_full = ($urandom_range(0, 7) == 0) ? NQ'($urandom) : '0;
      mk(len, et, $urandom_range(0, 4) != 0);
      run_frame($urandom_range(0, 2), 0, -1, 24);
      q_afull = '0; desc_full = '0;
    end

    // reset in the middle of a frame body
    class_type = {16'h88F7, 16'h0000}; class_en = 2'b10;
    strict = 1'b0; d0 = desc_total;
    repeat (40) begin @(posedge rx_clk); #1; rx_dv = 1'b1; rx_en = 1'b1; rx_d = 8'($urandom); end
    @(posedge rx_clk); #1 rstn_mac = 1'b0;
    @(posedge rx_clk);
    @(negedge rx_clk);
    chk_zero("midreset");
    #1 rstn_mac = 1'b1; w0 = wr_total;
    repeat (10) begin @(posedge rx_clk); #1; rx_d = 8'($urandom); end
    @(posedge rx_clk); #1 rx_dv = 1'b0;
    repeat (24) @(posedge rx_clk);
    chk("midreset_no_desc", desc_total - d0, 0);
    chk("midreset_ignore_tail", wr_total - w0, 0);
    for (int k = 0; k < NQ; k++) m_drop[k] = 0;
    m_runt = 0;
    exp_b.delete(); exp_q.delete(); exp_d.delete(); exp_dq.delete();
    strict = 1'b1;
    mk(64, 16'h88F7, 1);
    run_frame(0, 0, -1, 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
